// File: rtl/rv_pipe_hazard_ctrl.sv
// Pipeline hazard control for the RV32I in-order core: per-stage scoreboard,
// load-use / busy-EX stalls, redirect flush, N-way forwarding selects and a retire counter.
module rv_pipe_hazard_ctrl #(
    parameter int RF_ADDRESS = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 32,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [RF_ADDRESS-1:0] id_rs1,
    input  logic [RF_ADDRESS-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [RF_ADDRESS-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  ex_busy,
    input  logic                  redirect,
    output logic                  stall_fetch,
    output logic                  bubble_ex,
    output logic                  flush_ifid,
    output logic [SEL_W-1:0]      fwd_a_sel,
    output logic [SEL_W-1:0]      fwd_b_sel,
    output logic [DEPTH-1:0]      stage_valid,
    output logic [CNT_W-1:0]      retired
);

    logic [DEPTH:1]        r_valid;
    logic [DEPTH:1]        r_regwrite;
    logic [DEPTH:1]        r_memread;
    logic [RF_ADDRESS-1:0] r_rd [1:DEPTH];
    logic [RF_ADDRESS-1:0] r_rs1;
    logic [RF_ADDRESS-1:0] r_rs2;
    logic                  r_use_rs1;
    logic                  r_use_rs2;
    logic [CNT_W-1:0]      r_retired;
    logic                  w_load_use;

    // A load in stage k has data on a result bus only from stage 2+LOAD_LAT onward.
    function automatic logic [SEL_W-1:0] fwd_sel(input logic [RF_ADDRESS-1:0] src,
                                                 input logic                  use_src);
        logic [SEL_W-1:0] sel;
        sel = '0;
        for (int unsigned k = DEPTH; k >= 2; k--) begin
            if (use_src && (src != '0) && r_valid[k] && r_regwrite[k] && (r_rd[k] == src) &&
                (!r_memread[k] || (k >= 2 + LOAD_LAT)))
                sel = SEL_W'(k);
        end
        return sel;
    endfunction

    always_comb begin
        w_load_use = 1'b0;
        for (int unsigned k = 1; k <= LOAD_LAT; k++) begin
            if (id_valid && r_valid[k] && r_memread[k] && (r_rd[k] != '0) &&
                ((id_use_rs1 && (id_rs1 == r_rd[k])) || (id_use_rs2 && (id_rs2 == r_rd[k]))))
                w_load_use = 1'b1;
        end
    end

    always_comb begin
        stall_fetch = 1'b0;
        bubble_ex   = 1'b0;
        flush_ifid  = 1'b0;
        if (ex_busy) begin
            stall_fetch = 1'b1;
        end else if (redirect) begin
            flush_ifid = 1'b1;
        end else if (w_load_use) begin
            stall_fetch = 1'b1;
            bubble_ex   = 1'b1;
        end
    end

    always_comb begin
        fwd_a_sel = fwd_sel(r_rs1, r_use_rs1);
        fwd_b_sel = fwd_sel(r_rs2, r_use_rs2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= '0;
            r_retired <= '0;
        end else begin
            if (r_valid[DEPTH])
                r_retired <= r_retired + CNT_W'(1);
            for (int unsigned k = 3; k <= DEPTH; k++)
                r_valid[k] <= r_valid[k-1];
            if (ex_busy) begin
                r_valid[2] <= 1'b0;
            end else begin
                r_valid[2] <= r_valid[1];
                r_valid[1] <= id_valid & ~bubble_ex & ~redirect;
            end
        end
    end

    // Payload fields need no reset; they are qualified by r_valid everywhere.
    always_ff @(posedge clk) begin
        for (int unsigned k = 3; k <= DEPTH; k++) begin
            r_rd[k]       <= r_rd[k-1];
            r_regwrite[k] <= r_regwrite[k-1];
            r_memread[k]  <= r_memread[k-1];
        end
        if (!ex_busy) begin
            r_rd[2]       <= r_rd[1];
            r_regwrite[2] <= r_regwrite[1];
            r_memread[2]  <= r_memread[1];
            r_rd[1]       <= id_rd;
            r_regwrite[1] <= id_regwrite;
            r_memread[1]  <= id_memread;
            r_rs1         <= id_rs1;
            r_rs2         <= id_rs2;
            r_use_rs1     <= id_use_rs1;
            r_use_rs2     <= id_use_rs2;
        end
    end

    assign stage_valid = r_valid;
    assign retired     = r_retired;

endmodule
